handshake_skid: RTL and testbench

- Two-entry skid buffer (register slice) that sits directly downstream of the valid/ready relay stage and consumes its valid_o/data_o stream.
- Breaks the combinational ready path: ready_o toward the upstream stage is a pure flop output.
- Sustains one transfer per cycle with a fixed one-cycle forward latency.
- Presents a registered valid/data stream to the next slave.

---
 rtl/handshake_pkg.sv | 20 ++
 rtl/handshake_skid.sv | 111 +++++++++++
 tb/tb_handshake_skid.sv | 207 ++++++++++++++++++++
 3 files changed

// File: rtl/handshake_pkg.sv
// Shared definitions for the two-entry valid/ready skid buffer.
package handshake_pkg;

  localparam int LEVEL_W = 2;

  // Buffer state encoding. The value 3 is never produced and is handled as empty.
  localparam logic [1:0] ST_EMPTY = 2'd0;
  localparam logic [1:0] ST_BUSY  = 2'd1;
  localparam logic [1:0] ST_FULL  = 2'd2;

  // Number of beats held in the buffer for a given state.
  function automatic logic [LEVEL_W-1:0] level_of(input logic [1:0] st);
    case (st)
      ST_BUSY: level_of = 2'd1;
      ST_FULL: level_of = 2'd2;
      default: level_of = 2'd0;
    endcase
  endfunction

endpackage

// File: rtl/handshake_skid.sv
// Two-entry skid buffer (register slice) for a valid/ready stream.
//
// Handshake: a beat moves on a rising clk edge when valid and ready are both
// high on that interface. Upstream accept is acc = valid_i && ready_o.
// Downstream take is take = valid_o && ready_i. A producer holds valid/data
// steady until the beat moves. ready_o, valid_o, data_o and level_o all come
// straight from flops. No combinational path runs from ready_i to ready_o or
// from valid_i to valid_o.
//
// r_data feeds data_o. r_skid holds the second beat while the buffer is FULL.
// level_o equals the state encoding, so it also serves as the FSM debug view.
module handshake_skid
  import handshake_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic               valid_i,
  output logic               ready_o,
  input  logic [WIDTH-1:0]   data_i,
  output logic               valid_o,
  input  logic               ready_i,
  output logic [WIDTH-1:0]   data_o,
  output logic [LEVEL_W-1:0] level_o
);

  logic [1:0]         r_state;
  logic               r_ready;
  logic               r_valid;
  logic [LEVEL_W-1:0] r_level;
  logic [WIDTH-1:0]   r_data;
  logic [WIDTH-1:0]   r_skid;

  logic               w_acc;
  logic               w_take;
  logic [1:0]         w_next_state;
  logic               w_ready_nxt;
  logic               w_valid_nxt;
  logic [LEVEL_W-1:0] w_level_nxt;

  assign w_acc  = valid_i && r_ready;
  assign w_take = r_valid && ready_i;

  assign ready_o = r_ready;
  assign valid_o = r_valid;
  assign data_o  = r_data;
  assign level_o = r_level;

  // State register with the registered handshake and occupancy outputs.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state <= ST_EMPTY;
      r_ready <= 1'b0;
      r_valid <= 1'b0;
      r_level <= '0;
    end else begin
      r_state <= w_next_state;
      r_ready <= w_ready_nxt;
      r_valid <= w_valid_nxt;
      r_level <= w_level_nxt;
    end
  end

  // Next state from the accept and take events.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_BUSY: begin
        if (w_acc && !w_take)      w_next_state = ST_FULL;
        else if (!w_acc && w_take) w_next_state = ST_EMPTY;
      end
      ST_FULL: begin
        if (w_take) w_next_state = ST_BUSY;
      end
      default: begin
        // EMPTY, and the unused encoding recovers as EMPTY.
        w_next_state = w_acc ? ST_BUSY : ST_EMPTY;
      end
    endcase
  end

  // Output values to be registered, all decoded from the next state.
  always_comb begin
    w_ready_nxt = (w_next_state != ST_FULL);
    w_valid_nxt = (w_next_state != ST_EMPTY);
    w_level_nxt = level_of(w_next_state);
  end

  // Payload registers. data_o keeps its last value while empty.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_data <= '0;
      r_skid <= '0;
    end else begin
      case (r_state)
        ST_BUSY: begin
          if (w_acc && w_take)       r_data <= data_i;
          else if (w_acc && !w_take) r_skid <= data_i;
        end
        ST_FULL: begin
          if (w_take) r_data <= r_skid;
        end
        default: begin
          if (w_acc) r_data <= data_i;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_handshake_skid.sv
// Self-checking bench for handshake_skid with a queue-based reference model.
module tb_handshake_skid;

  localparam int W = 32;

  logic         clk;
  logic         rstn;
  logic         valid_i;
  logic         ready_o;
  logic [W-1:0] data_i;
  logic         valid_o;
  logic         ready_i;
  logic [W-1:0] data_o;
  logic [1:0]   level_o;

  handshake_skid #(.WIDTH(W)) dut (
    .clk     (clk),
    .rstn    (rstn),
    .valid_i (valid_i),
    .ready_o (ready_o),
    .data_i  (data_i),
    .valid_o (valid_o),
    .ready_i (ready_i),
    .data_o  (data_o),
    .level_o (level_o)
  );

  // Clock and reset defaults.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: the buffer is a queue of at most two beats. The front
  // beat is what the slave sees. ready is low during reset and is otherwise
  // high whenever fewer than two beats are held.
  logic [W-1:0] exp_q[$];
  logic         m_ready;
  logic [W-1:0] m_data;

  // Results of the last tick, for scoreboard checks on taken beats.
  logic         t_take;
  logic         t_acc;
  logic [W-1:0] t_got;
  logic [W-1:0] t_exp;

  task automatic model_reset();
    exp_q.delete();
    m_ready = 1'b0;
    m_data  = '0;
  endtask

  // Drives one cycle from a negedge, advances the model at the posedge and
  // returns at the next negedge.
  task automatic tick(input logic v, input logic [W-1:0] d, input logic r);
    valid_i = v;
    data_i  = d;
    ready_i = r;
    t_acc   = v && m_ready;
    t_take  = (exp_q.size() > 0) && r;
    t_got   = data_o;
    t_exp   = (exp_q.size() > 0) ? exp_q[0] : '0;
    @(posedge clk);
    if (t_take) void'(exp_q.pop_front());
    if (t_acc) exp_q.push_back(d);
    m_ready = (exp_q.size() < 2);
    if (exp_q.size() > 0) m_data = exp_q[0];
    @(negedge clk);
  endtask

  task automatic test_reset();
    rstn = 1'b0; valid_i = 1'b0; ready_i = 1'b0; data_i = '0;
    model_reset();
    repeat (2) @(negedge clk);
    n_checks++; if (ready_o !== 1'b0) $display("FAIL reset_ready: got %b expected 0", ready_o); else n_pass++;
    n_checks++; if (valid_o !== 1'b0) $display("FAIL reset_valid: got %b expected 0", valid_o); else n_pass++;
    n_checks++; if (level_o !== 2'd0) $display("FAIL reset_level: got %0d expected 0", level_o); else n_pass++;
    n_checks++; if (data_o !== '0) $display("FAIL reset_data: got %h expected 0", data_o); else n_pass++;
    rstn = 1'b1;
    #1;
    n_checks++; if (ready_o !== 1'b0) $display("FAIL release_ready_early: got %b expected 0", ready_o); else n_pass++;
    @(negedge clk);
    tick(1'b0, '0, 1'b0);
    n_checks++; if (ready_o !== 1'b1) $display("FAIL release_ready: got %b expected 1", ready_o); else n_pass++;
    n_checks++; if (valid_o !== 1'b0) $display("FAIL release_valid: got %b expected 0", valid_o); else n_pass++;
  endtask

  task automatic test_stream();
    logic [W-1:0] beats [3];
    beats[0] = 32'h11; beats[1] = 32'h22; beats[2] = 32'h33;
    for (int i = 0; i < 3; i++) begin
      n_checks++; if (ready_o !== 1'b1) $display("FAIL stream_ready_%0d: got %b expected 1", i, ready_o); else n_pass++;
      tick(1'b1, beats[i], 1'b1);
      n_checks++; if (data_o !== beats[i]) $display("FAIL stream_data_%0d: got %h expected %h", i, data_o, beats[i]); else n_pass++;
      n_checks++; if (level_o !== 2'd1) $display("FAIL stream_level_%0d: got %0d expected 1", i, level_o); else n_pass++;
      n_checks++; if (valid_o !== 1'b1) $display("FAIL stream_valid_%0d: got %b expected 1", i, valid_o); else n_pass++;
    end
    tick(1'b0, '0, 1'b1);
    n_checks++; if (valid_o !== 1'b0) $display("FAIL stream_drain_valid: got %b expected 0", valid_o); else n_pass++;
    n_checks++; if (data_o !== 32'h33) $display("FAIL stream_hold_data: got %h expected 33", data_o); else n_pass++;
  endtask

  task automatic test_backpressure();
    tick(1'b1, 32'hA1, 1'b0);
    tick(1'b1, 32'hA2, 1'b0);
    n_checks++; if (level_o !== 2'd2) $display("FAIL bp_level_full: got %0d expected 2", level_o); else n_pass++;
    n_checks++; if (ready_o !== 1'b0) $display("FAIL bp_ready_full: got %b expected 0", ready_o); else n_pass++;
    n_checks++; if (data_o !== 32'hA1) $display("FAIL bp_data_full: got %h expected a1", data_o); else n_pass++;
    // An offered beat while full must not be accepted.
    tick(1'b1, 32'hEE, 1'b0);
    n_checks++; if (data_o !== 32'hA1) $display("FAIL bp_data_hold: got %h expected a1", data_o); else n_pass++;
    tick(1'b0, '0, 1'b1);
    n_checks++; if (t_got !== 32'hA1) $display("FAIL bp_take1: got %h expected a1", t_got); else n_pass++;
    n_checks++; if (level_o !== 2'd1) $display("FAIL bp_level_one: got %0d expected 1", level_o); else n_pass++;
    n_checks++; if (data_o !== 32'hA2) $display("FAIL bp_data_second: got %h expected a2", data_o); else n_pass++;
    n_checks++; if (ready_o !== 1'b1) $display("FAIL bp_ready_one: got %b expected 1", ready_o); else n_pass++;
    tick(1'b0, '0, 1'b1);
    n_checks++; if (t_got !== 32'hA2) $display("FAIL bp_take2: got %h expected a2", t_got); else n_pass++;
    n_checks++; if (level_o !== 2'd0) $display("FAIL bp_level_empty: got %0d expected 0", level_o); else n_pass++;
    n_checks++; if (valid_o !== 1'b0) $display("FAIL bp_valid_empty: got %b expected 0", valid_o); else n_pass++;
  endtask

  task automatic test_simultaneous();
    tick(1'b1, 32'h44, 1'b0);
    tick(1'b1, 32'h5A, 1'b1);
    n_checks++; if (t_got !== 32'h44) $display("FAIL simul_take: got %h expected 44", t_got); else n_pass++;
    n_checks++; if (level_o !== 2'd1) $display("FAIL simul_level: got %0d expected 1", level_o); else n_pass++;
    n_checks++; if (data_o !== 32'h5A) $display("FAIL simul_data: got %h expected 5a", data_o); else n_pass++;
    tick(1'b0, '0, 1'b1);
    n_checks++; if (level_o !== 2'd0) $display("FAIL simul_drain: got %0d expected 0", level_o); else n_pass++;
  endtask

  task automatic test_mid_reset();
    tick(1'b1, 32'hB1, 1'b0);
    tick(1'b1, 32'hB2, 1'b0);
    n_checks++; if (level_o !== 2'd2) $display("FAIL mr_full: got %0d expected 2", level_o); else n_pass++;
    valid_i = 1'b0;
    #2 rstn = 1'b0;
    model_reset();
    #1;
    n_checks++; if (valid_o !== 1'b0) $display("FAIL mr_valid: got %b expected 0", valid_o); else n_pass++;
    n_checks++; if (ready_o !== 1'b0) $display("FAIL mr_ready: got %b expected 0", ready_o); else n_pass++;
    n_checks++; if (level_o !== 2'd0) $display("FAIL mr_level: got %0d expected 0", level_o); else n_pass++;
    n_checks++; if (data_o !== '0) $display("FAIL mr_data: got %h expected 0", data_o); else n_pass++;
    @(negedge clk);
    rstn = 1'b1;
    tick(1'b0, '0, 1'b1);
    tick(1'b1, 32'hC3, 1'b1);
    n_checks++; if (data_o !== 32'hC3) $display("FAIL mr_c3: got %h expected c3", data_o); else n_pass++;
    n_checks++; if (level_o !== 2'd1) $display("FAIL mr_c3_level: got %0d expected 1", level_o); else n_pass++;
    tick(1'b0, '0, 1'b1);
    n_checks++; if (valid_o !== 1'b0) $display("FAIL mr_no_stale: got %b expected 0", valid_o); else n_pass++;
    n_checks++; if (data_o !== 32'hC3) $display("FAIL mr_hold: got %h expected c3", data_o); else n_pass++;
  endtask

  task automatic test_random();
    int           n_acc;
    int           n_take;
    int           cyc;
    logic         stall;
    logic [W-1:0] held;
    n_acc = 0; n_take = 0; cyc = 0;
    while (n_acc < 1000 && cyc < 20000) begin
      stall = 1'b0;
      held  = data_o;
      tick(1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 1)));
      stall = valid_i === 1'b0 ? 1'b0 : 1'b0;
      cyc++;
      if (t_acc) n_acc++;
      if (t_take) begin
        n_take++;
        n_checks++; if (t_got !== t_exp) $display("FAIL rnd_take_%0d: got %h expected %h", n_take, t_got, t_exp); else n_pass++;
      end
      if (!ready_i && (t_exp === held) && (exp_q.size() > 0)) begin
        n_checks++; if (data_o !== held) $display("FAIL rnd_stable_%0d: got %h expected %h", cyc, data_o, held); else n_pass++;
      end
      n_checks++; if (valid_o !== (exp_q.size() > 0)) $display("FAIL rnd_valid_%0d: got %b expected %b", cyc, valid_o, exp_q.size() > 0); else n_pass++;
      n_checks++; if (ready_o !== m_ready) $display("FAIL rnd_ready_%0d: got %b expected %b", cyc, ready_o, m_ready); else n_pass++;
      n_checks++; if (level_o !== 2'(exp_q.size())) $display("FAIL rnd_level_%0d: got %0d expected %0d", cyc, level_o, exp_q.size()); else n_pass++;
      n_checks++; if (data_o !== m_data) $display("FAIL rnd_data_%0d: got %h expected %h", cyc, data_o, m_data); else n_pass++;
    end
    n_checks++; if (n_acc < 1000) $display("FAIL rnd_budget: got %0d accepted expected 1000", n_acc); else n_pass++;
    for (int i = 0; i < 4; i++) begin
      tick(1'b0, '0, 1'b1);
      if (t_take) begin
        n_take++;
        n_checks++; if (t_got !== t_exp) $display("FAIL rnd_drain_take: got %h expected %h", t_got, t_exp); else n_pass++;
      end
    end
    n_checks++; if (level_o !== 2'd0) $display("FAIL rnd_final_level: got %0d expected 0", level_o); else n_pass++;
    n_checks++; if (n_take !== n_acc) $display("FAIL rnd_count: got %0d taken expected %0d", n_take, n_acc); else n_pass++;
    if (stall) $display("unused");
  endtask

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_simultaneous();
    test_mid_reset();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
